// File: rtl/rcswitch_receive_pkg.sv
// Shared constants, state type and pulse classifier for the rc-switch
// tristate frame receiver.
package rcswitch_receive_pkg;

    localparam int FRAME_PULSES = 24;
    localparam int ADDR_W       = 40;
    localparam int CHAN_W       = 40;
    localparam int STAT_W       = 16;
    localparam int FRAME_W      = ADDR_W + CHAN_W + STAT_W;
    localparam int PCNT_W       = $clog2(FRAME_PULSES + 1);

    localparam logic [3:0]  CODE_SHORT = 4'h8;
    localparam logic [3:0]  CODE_LONG  = 4'hE;
    localparam logic [15:0] STAT_ON    = 16'h888E;
    localparam logic [15:0] STAT_OFF   = 16'h8E88;

    typedef enum logic [0:0] {
        HUNT  = 1'b0,
        ARMED = 1'b1
    } rx_state_t;

    // A short high phase followed by a longer low phase is the "8" symbol.
    function automatic logic [3:0] classify_pulse(input int unsigned hiTicks,
                                                  input int unsigned loTicks);
        return (hiTicks < loTicks) ? CODE_SHORT : CODE_LONG;
    endfunction

endpackage

// File: rtl/rcswitch_receive_clockdiv.sv
// Sample-tick generator: a single-cycle enable every 2*DIV clocks.
// The tick is a clock enable, never used as a clock.
module clockdiv #(
    parameter int DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int LAST  = 2 * DIV - 1;
    localparam int CNT_W = (LAST > 0) ? $clog2(LAST + 1) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == CNT_W'(LAST)) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/rcswitch_receive.sv
// rc-switch / PT2262 tristate receiver: measures pulse widths on the sample
// tick, classifies each pulse and latches a 24-pulse frame into addr/chan/stat.
module rcswitch_receive
    import rcswitch_receive_pkg::*;
#(
    parameter int CLK_DIV  = 1000,
    parameter int SYNC_MIN = 20,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in,
    output logic [ADDR_W-1:0] addr,
    output logic [CHAN_W-1:0] chan,
    output logic [STAT_W-1:0] stat,
    output logic              ready
);

    logic              w_tick;
    logic              w_in;
    logic              w_rise;
    logic              w_sync;
    logic              w_pulse;
    logic [3:0]        w_code;
    logic [FRAME_W-1:0] w_sr_nx;
    logic              w_shift;
    logic              w_latch;
    logic              w_arm;
    rx_state_t         w_state_nx;

    logic              r_sync1;
    logic              r_sync2;
    logic              r_prev;
    logic [CNT_W-1:0]  r_hi_cnt;
    logic [CNT_W-1:0]  r_lo_cnt;
    // The 24th code is taken straight from w_sr_nx, so only 23 codes are stored.
    logic [FRAME_W-5:0] r_sr;
    logic [PCNT_W-1:0] r_pcnt;
    rx_state_t         r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [CHAN_W-1:0] r_chan;
    logic [STAT_W-1:0] r_stat;
    logic              r_ready;

    clockdiv #(.DIV(CLK_DIV)) u_clockdiv (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    assign w_in    = r_sync2;
    assign w_rise  = w_tick && !r_prev && w_in;
    // lo_cnt passes SYNC_MIN-1 exactly once per low phase, so sync fires once.
    assign w_sync  = w_tick && !w_in && (r_lo_cnt == CNT_W'(SYNC_MIN - 1));
    assign w_pulse = w_rise && (r_hi_cnt != '0);
    assign w_code  = classify_pulse(32'(r_hi_cnt), 32'(r_lo_cnt));
    assign w_sr_nx = {r_sr, w_code};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_shift    = 1'b0;
        w_latch    = 1'b0;
        w_arm      = 1'b0;
        if (w_sync) begin
            w_state_nx = ARMED;
            w_arm      = 1'b1;
        end else if (w_pulse && (r_state == ARMED)) begin
            w_shift = 1'b1;
            if (r_pcnt == PCNT_W'(FRAME_PULSES - 1)) begin
                w_latch    = 1'b1;
                w_state_nx = HUNT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_prev   <= 1'b0;
            r_hi_cnt <= '0;
            r_lo_cnt <= '0;
        end else begin
            r_sync1 <= in;
            r_sync2 <= r_sync1;
            if (w_tick) begin
                r_prev <= w_in;
                if (w_rise) begin
                    r_hi_cnt <= CNT_W'(1);
                    r_lo_cnt <= '0;
                end else if (w_in) begin
                    if (r_hi_cnt != '1) r_hi_cnt <= r_hi_cnt + 1'b1;
                end else begin
                    if (r_lo_cnt != '1) r_lo_cnt <= r_lo_cnt + 1'b1;
                    // Zeroing hi_cnt makes the pulse carrying the sync gap be ignored.
                    if (w_sync) r_hi_cnt <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr    <= '0;
            r_pcnt  <= '0;
            r_addr  <= '0;
            r_chan  <= '0;
            r_stat  <= '0;
            r_ready <= 1'b0;
        end else begin
            if (w_arm) begin
                r_sr   <= '0;
                r_pcnt <= '0;
            end else if (w_shift) begin
                r_sr   <= w_sr_nx[FRAME_W-5:0];
                r_pcnt <= r_pcnt + 1'b1;
                if (r_pcnt == '0) r_ready <= 1'b0;
            end
            if (w_latch) begin
                r_addr  <= w_sr_nx[FRAME_W-1 -: ADDR_W];
                r_chan  <= w_sr_nx[STAT_W + CHAN_W - 1 -: CHAN_W];
                r_stat  <= w_sr_nx[STAT_W-1:0];
                r_ready <= 1'b1;
            end
        end
    end

    assign addr  = r_addr;
    assign chan  = r_chan;
    assign stat  = r_stat;
    assign ready = r_ready;

endmodule

// File: tb/tb_rcswitch_receive.sv
// Scoreboard bench for rcswitch_receive: pulse-level stimulus, frame-level
// reference model, and a monitor that checks each ready rise.
module tb_rcswitch_receive;
    import rcswitch_receive_pkg::*;

    localparam int TICK_CLKS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in  = 1'b1;
    logic [39:0] addr;
    logic [39:0] chan;
    logic [15:0] stat;
    logic        ready;
    logic        divTick;

    typedef struct packed {
        logic [39:0] a;
        logic [39:0] c;
        logic [15:0] s;
    } frame_t;

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    int unsigned lastRiseCyc = 0;
    int          risesSeen = 0;
    int          risesExp  = 0;

    frame_t      expQ[$];
    logic [3:0]  codesQ[$];
    bit          armedM    = 1'b0;
    bit          pendValid = 1'b0;
    logic [3:0]  pendCode  = 4'h0;
    logic        readyM    = 1'b0;
    frame_t      heldM     = '0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    rcswitch_receive #(.CLK_DIV(2), .SYNC_MIN(20), .CNT_W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .in    (in),
        .addr  (addr),
        .chan  (chan),
        .stat  (stat),
        .ready (ready)
    );

    clockdiv #(.DIV(3)) divDut (
        .clk  (clk),
        .rst  (rst),
        .tick (divTick)
    );

    task automatic checkOutput(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at cyc %0d", name, act, exp, cyc);
        end
    endtask

    task automatic waitTicks(input int n);
        repeat (n * TICK_CLKS) @(negedge clk);
    endtask

    // A rising edge closes the pending pulse; the model decides what it means.
    task automatic riseEdge(output bit firstDone);
        frame_t f;
        firstDone = 1'b0;
        if (in == 1'b0) begin
            lastRiseCyc = cyc;
            if (pendValid && armedM) begin
                codesQ.push_back(pendCode);
                if (codesQ.size() == 1) begin
                    firstDone = 1'b1;
                    readyM    = 1'b0;
                end
                if (codesQ.size() == FRAME_PULSES) begin
                    f = '0;
                    for (int i = 0; i < 10; i++) f.a = {f.a[35:0], codesQ[i]};
                    for (int i = 10; i < 20; i++) f.c = {f.c[35:0], codesQ[i]};
                    for (int i = 20; i < 24; i++) f.s = {f.s[11:0], codesQ[i]};
                    expQ.push_back(f);
                    risesExp++;
                    heldM  = f;
                    readyM = 1'b1;
                    armedM = 1'b0;
                end
            end
        end
        pendValid = 1'b0;
        in = 1'b1;
    endtask

    task automatic applyStimulus(input int hiTicks, input int loTicks);
        bit firstDone;
        riseEdge(firstDone);
        waitTicks(hiTicks);
        in = 1'b0;
        waitTicks(loTicks);
        pendValid = 1'b1;
        pendCode  = (hiTicks < loTicks) ? CODE_SHORT : CODE_LONG;
        if (firstDone) checkOutput("ready_fall", 48'(ready), 48'(1'b0));
    endtask

    task automatic sendSync();
        bit firstDone;
        riseEdge(firstDone);
        waitTicks(2);
        in = 1'b0;
        waitTicks(62);
        if (firstDone) checkOutput("ready_fall_sync", 48'(ready), 48'(1'b0));
        armedM    = 1'b1;
        pendValid = 1'b0;
        codesQ.delete();
    endtask

    task automatic sendCode(input logic [3:0] code);
        if (code == CODE_SHORT) applyStimulus(2, 6);
        else                    applyStimulus(6, 2);
    endtask

    task automatic sendFrame(input logic [39:0] a, input logic [39:0] c, input logic [15:0] s);
        logic [95:0] w;
        w = {a, c, s};
        for (int i = 0; i < FRAME_PULSES; i++) sendCode(w[95 - 4*i -: 4]);
    endtask

    task automatic checkHeld(input string tag);
        checkOutput({tag, "_addr"},  48'(addr),  48'(heldM.a));
        checkOutput({tag, "_chan"},  48'(chan),  48'(heldM.c));
        checkOutput({tag, "_stat"},  48'(stat),  48'(heldM.s));
        checkOutput({tag, "_ready"}, 48'(ready), 48'(readyM));
    endtask

    task automatic resetMid();
        #2;
        rst = 1'b0;
        in  = 1'b1;
        #1;
        checkOutput("rst_addr",  48'(addr),  48'd0);
        checkOutput("rst_chan",  48'(chan),  48'd0);
        checkOutput("rst_stat",  48'(stat),  48'd0);
        checkOutput("rst_ready", 48'(ready), 48'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst       = 1'b1;
        armedM    = 1'b0;
        pendValid = 1'b0;
        readyM    = 1'b0;
        heldM     = '0;
        codesQ.delete();
        expQ.delete();
    endtask

    // Monitor: every ready rise must match the oldest expected frame.
    initial begin : monitor
        bit      prevReady;
        frame_t  e;
        int      delta;
        prevReady = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prevReady = 1'b0;
            end else begin
                if (ready && !prevReady) begin
                    risesSeen++;
                    if (expQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_ready: got rise with no frame expected at cyc %0d", cyc);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("sb_addr", 48'(addr), 48'(e.a));
                        checkOutput("sb_chan", 48'(chan), 48'(e.c));
                        checkOutput("sb_stat", 48'(stat), 48'(e.s));
                        delta = int'(cyc - lastRiseCyc);
                        checks++;
                        if (delta < 3 || delta > 6) begin
                            failures++;
                            $display("[TB] FAIL sb_latency: got %0d clk expected 3..6 clk", delta);
                        end
                    end
                end
                prevReady = ready;
            end
        end
    end

    initial begin : stimulus
        bit     dummy;
        frame_t r;
        int     n;

        repeat (2) @(negedge clk);
        checkOutput("init_addr",  48'(addr),  48'd0);
        checkOutput("init_chan",  48'(chan),  48'd0);
        checkOutput("init_stat",  48'(stat),  48'd0);
        checkOutput("init_ready", 48'(ready), 48'd0);

        rst = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            checkOutput("div_tick", 48'(divTick), 48'((k % 6) == 0));
        end

        $display("[TB] directed frame, state ON");
        sendSync();
        sendFrame(40'h8888888888, 40'h888E8E8E8E, STAT_ON);
        sendSync();
        checkOutput("f1_addr",  48'(addr),  48'h8888888888);
        checkOutput("f1_chan",  48'(chan),  48'h888E8E8E8E);
        checkOutput("f1_stat",  48'(stat),  48'(STAT_ON));
        checkOutput("f1_ready", 48'(ready), 48'd1);

        $display("[TB] repeated frame, state OFF");
        for (int rep = 0; rep < 2; rep++) begin
            sendFrame(40'h8888888888, 40'h8E8E8E888E, STAT_OFF);
            sendSync();
            checkOutput("f2_addr",  48'(addr),  48'h8888888888);
            checkOutput("f2_chan",  48'(chan),  48'h8E8E8E888E);
            checkOutput("f2_stat",  48'(stat),  48'(STAT_OFF));
            checkOutput("f2_ready", 48'(ready), 48'd1);
        end

        $display("[TB] truncated frame then full frame");
        for (int i = 0; i < 12; i++) sendCode(($urandom_range(0, 1) == 0) ? CODE_SHORT : CODE_LONG);
        sendSync();
        checkOutput("trunc_addr",  48'(addr),  48'h8888888888);
        checkOutput("trunc_chan",  48'(chan),  48'h8E8E8E888E);
        checkOutput("trunc_stat",  48'(stat),  48'(STAT_OFF));
        checkOutput("trunc_ready", 48'(ready), 48'd0);
        r.a = {$urandom, $urandom_range(0, 255)};
        r.c = {$urandom, $urandom_range(0, 255)};
        r.s = 16'($urandom);
        for (int i = 0; i < 24; i++) begin
            n = int'($urandom_range(0, 1));
            if (i < 10)      r.a[39 - 4*i -: 4]      = (n == 0) ? CODE_SHORT : CODE_LONG;
            else if (i < 20) r.c[39 - 4*(i-10) -: 4] = (n == 0) ? CODE_SHORT : CODE_LONG;
            else             r.s[15 - 4*(i-20) -: 4] = (n == 0) ? CODE_SHORT : CODE_LONG;
        end
        sendFrame(r.a, r.c, r.s);
        sendSync();
        checkHeld("full");

        $display("[TB] reset mid-stream, then frame without sync");
        for (int i = 0; i < 5; i++) sendCode(CODE_LONG);
        resetMid();
        sendFrame(40'h8888888888, 40'h888E8E8E8E, STAT_ON);
        riseEdge(dummy);
        waitTicks(10);
        checkHeld("nosync");

        $display("[TB] randomized frames");
        for (int f = 0; f < 8; f++) begin
            sendSync();
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 23)) : FRAME_PULSES;
            for (int i = 0; i < n; i++)
                applyStimulus(int'($urandom_range(1, 7)), int'($urandom_range(1, 7)));
            riseEdge(dummy);
            waitTicks(3);
            checkHeld("rand");
        end
        sendSync();
        waitTicks(4);
        checkHeld("final");

        checkOutput("sb_empty", 48'(expQ.size()), 48'd0);
        checkOutput("sb_rises", 48'(risesSeen), 48'(risesExp));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
